// File: rtl/cmd_frame_pkg.sv
// Shared constants for the framed command parser: frame bytes, error codes
// and the parser state encoding.
package cmd_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_START = 8'h02;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BADLEN  = 3'd1;
    localparam logic [2:0] ERR_CSUM    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_BADCMD  = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_LEN   = 3'd3,
        ST_DATA  = 3'd4,
        ST_CSUM  = 3'd5,
        ST_FLUSH = 3'd6
    } state_t;

endpackage

// File: rtl/cmd_frame_parser_frame_buf.sv
// Payload buffer for one WRITE frame: registered write port, combinational
// read port driven by the flush index.
module frame_buf #(
    parameter int MAX_LEN = 32,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [MAX_LEN];

    // No reset: contents are only ever read after being written by the same frame.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cmd_frame_parser.sv
// Framed command parser: SYNC CMD ADDR LEN payload CSUM, flushing payload to
// parameter RAM only after a good checksum. Optional CMD_FRAME_TIMEOUT_EN.
module cmd_frame_parser
    import cmd_frame_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       pc_start,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT < 2) begin : g_param_check
        $error("cmd_frame_parser: MAX_LEN must be 1..255 and TIMEOUT at least 2");
    end

    // Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte
    // is consumed on every cycle it is high, so there is no ready signal.

    state_t     state, state_n;
    logic [7:0] cmd_q, cmd_n;
    logic [7:0] addr_q, addr_n;
    logic [7:0] len_q, len_n;
    logic [7:0] csum_q, csum_n;
    logic [7:0] cnt_q, cnt_n;
    logic       wr_en_n, pc_start_n, frame_ok_n, frame_err_n;
    logic [7:0] wr_addr_n, wr_data_n;
    logic [2:0] err_code_n;
    logic       buf_we;
    logic [7:0] buf_rd;

`ifdef CMD_FRAME_TIMEOUT_EN
    logic [31:0] tmr_q, tmr_n;
`endif

    frame_buf #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W)
    ) u_frame_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_idx  (cnt_q[IDX_W-1:0]),
        .wr_data (rx_data),
        .rd_idx  (cnt_q[IDX_W-1:0]),
        .rd_data (buf_rd)
    );

    always_comb begin
        state_n     = state;
        cmd_n       = cmd_q;
        addr_n      = addr_q;
        len_n       = len_q;
        csum_n      = csum_q;
        cnt_n       = cnt_q;
        wr_en_n     = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        pc_start_n  = 1'b0;
        frame_ok_n  = 1'b0;
        frame_err_n = 1'b0;
        err_code_n  = err_code;
        buf_we      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_n = ST_CMD;
                    csum_n  = 8'h00;
                    cnt_n   = 8'h00;
                end
            end
            ST_CMD: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_START) begin
                        cmd_n   = rx_data;
                        csum_n  = csum_q ^ rx_data;
                        state_n = ST_ADDR;
                    end else begin
                        frame_err_n = 1'b1;
                        err_code_n  = ERR_BADCMD;
                        state_n     = ST_IDLE;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    addr_n  = rx_data;
                    csum_n  = csum_q ^ rx_data;
                    state_n = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    len_n  = rx_data;
                    csum_n = csum_q ^ rx_data;
                    if (cmd_q == CMD_START) begin
                        if (rx_data != 8'h00) begin
                            frame_err_n = 1'b1;
                            err_code_n  = ERR_BADLEN;
                            state_n     = ST_IDLE;
                        end else begin
                            state_n = ST_CSUM;
                        end
                    end else if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                        frame_err_n = 1'b1;
                        err_code_n  = ERR_BADLEN;
                        state_n     = ST_IDLE;
                    end else begin
                        state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    buf_we = 1'b1;
                    csum_n = csum_q ^ rx_data;
                    cnt_n  = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        cnt_n   = 8'h00;
                        state_n = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data != csum_q) begin
                        frame_err_n = 1'b1;
                        err_code_n  = ERR_CSUM;
                        state_n     = ST_IDLE;
                    end else if (cmd_q == CMD_START) begin
                        pc_start_n = 1'b1;
                        frame_ok_n = 1'b1;
                        state_n    = ST_IDLE;
                    end else begin
                        // First write goes out with the state change; cnt is 0 here.
                        wr_en_n   = 1'b1;
                        wr_addr_n = addr_q;
                        wr_data_n = buf_rd;
                        cnt_n     = 8'd1;
                        state_n   = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_q == len_q) begin
                    frame_ok_n = 1'b1;
                    state_n    = ST_IDLE;
                end else begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = addr_q + cnt_q;
                    wr_data_n = buf_rd;
                    cnt_n     = cnt_q + 8'd1;
                end
                if (rx_valid) begin
                    frame_err_n = 1'b1;
                    err_code_n  = ERR_OVERRUN;
                end
            end
            default: state_n = ST_IDLE;
        endcase

`ifdef CMD_FRAME_TIMEOUT_EN
        tmr_n = tmr_q;
        if (rx_valid) begin
            tmr_n = 32'd1;
        end else if (state != ST_IDLE && state != ST_FLUSH) begin
            tmr_n = tmr_q + 32'd1;
            if (tmr_q == 32'(TIMEOUT - 1)) begin
                frame_err_n = 1'b1;
                err_code_n  = ERR_TIMEOUT;
                state_n     = ST_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_q     <= 8'h00;
            addr_q    <= 8'h00;
            len_q     <= 8'h00;
            csum_q    <= 8'h00;
            cnt_q     <= 8'h00;
            wr_en     <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            pc_start  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_q     <= cmd_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            csum_q    <= csum_n;
            cnt_q     <= cnt_n;
            wr_en     <= wr_en_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
            pc_start  <= pc_start_n;
            frame_ok  <= frame_ok_n;
            frame_err <= frame_err_n;
            err_code  <= err_code_n;
            busy      <= (state_n != ST_IDLE);
        end
    end

`ifdef CMD_FRAME_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q <= 32'd0;
        end else begin
            tmr_q <= tmr_n;
        end
    end
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Randomized and directed bench for cmd_frame_parser; a frame-level model
// predicts every write, pulse and error code with its cycle.
module tb_cmd_frame_parser;

    localparam int MAX_LEN = 8;
    localparam int TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       pc_start;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;
    logic       busy;
    logic [2:0] state_dbg;

    cmd_frame_parser #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pc_start  (pc_start),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [2:0] exp_last_code = 3'd0;

    // {cycle, addr, data}, {cycle, code}, cycle, cycle
    logic [47:0] exp_wr_q[$];
    logic [34:0] exp_err_q[$];
    logic [31:0] exp_ok_q[$];
    logic [31:0] exp_start_q[$];
    logic [7:0]  pay_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sample();
        logic [47:0] w;
        logic [34:0] e;
        logic [31:0] c;
        if (wr_en) begin
            if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'(wr_en), 32'd0);
            else begin
                w = exp_wr_q.pop_front();
                chk("wr_cycle", 32'(cyc), w[47:16]);
                chk("wr_addr", 32'(wr_addr), 32'(w[15:8]));
                chk("wr_data", 32'(wr_data), 32'(w[7:0]));
            end
        end else if (exp_wr_q.size() != 0 && exp_wr_q[0][47:16] == 32'(cyc)) begin
            chk("wr_missing", 32'(wr_en), 32'd1);
            void'(exp_wr_q.pop_front());
        end
        if (frame_err) begin
            if (exp_err_q.size() == 0) chk("err_unexpected", 32'(frame_err), 32'd0);
            else begin
                e = exp_err_q.pop_front();
                chk("err_cycle", 32'(cyc), e[34:3]);
                chk("err_code", 32'(err_code), 32'(e[2:0]));
            end
        end else if (exp_err_q.size() != 0 && exp_err_q[0][34:3] == 32'(cyc)) begin
            chk("err_missing", 32'(frame_err), 32'd1);
            void'(exp_err_q.pop_front());
        end
        if (frame_ok) begin
            if (exp_ok_q.size() == 0) chk("ok_unexpected", 32'(frame_ok), 32'd0);
            else begin
                c = exp_ok_q.pop_front();
                chk("ok_cycle", 32'(cyc), c);
                chk("ok_busy_low", 32'(busy), 32'd0);
            end
        end else if (exp_ok_q.size() != 0 && exp_ok_q[0] == 32'(cyc)) begin
            chk("ok_missing", 32'(frame_ok), 32'd1);
            void'(exp_ok_q.pop_front());
        end
        if (pc_start) begin
            if (exp_start_q.size() == 0) chk("start_unexpected", 32'(pc_start), 32'd0);
            else begin
                c = exp_start_q.pop_front();
                chk("start_cycle", 32'(cyc), c);
            end
        end else if (exp_start_q.size() != 0 && exp_start_q[0] == 32'(cyc)) begin
            chk("start_missing", 32'(pc_start), 32'd1);
            void'(exp_start_q.pop_front());
        end
    endtask

    // Byte driven during cycle cyc; outputs it causes are seen from cycle cyc+1.
    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        cyc++;
        rx_valid = 1'b0;
        sample();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic gap(input int max_gap);
        idle(int'($urandom_range(0, max_gap)));
    endtask

    task automatic push_err(input int at, input logic [2:0] code);
        exp_err_q.push_back({32'(at), code});
        exp_last_code = code;
    endtask

    // Frame-level model: decides the outcome from the fields, stops sending
    // at the byte that is rejected, and schedules every expected output.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] len, input logic [7:0] csum_delta,
                             input int max_gap, input bit overrun);
        logic [7:0] cs;
        logic [7:0] a;
        send(8'hA5);
        gap(max_gap);
        if (cmd != 8'h01 && cmd != 8'h02) begin
            push_err(cyc + 1, 3'd4);
            send(cmd);
            idle(2);
        end else begin
            send(cmd);
            gap(max_gap);
            send(addr);
            gap(max_gap);
            if ((cmd == 8'h01) ? (len == 0 || int'(len) > MAX_LEN) : (len != 0)) begin
                push_err(cyc + 1, 3'd1);
                send(len);
                idle(2);
            end else begin
                send(len);
                cs = cmd ^ addr ^ len;
                for (int i = 0; i < int'(len); i++) begin
                    gap(max_gap);
                    send(pay_q[i]);
                    cs = cs ^ pay_q[i];
                end
                gap(max_gap);
                if (csum_delta != 0) begin
                    push_err(cyc + 1, 3'd2);
                end else if (cmd == 8'h02) begin
                    exp_ok_q.push_back(32'(cyc + 1));
                    exp_start_q.push_back(32'(cyc + 1));
                end else begin
                    for (int i = 0; i < int'(len); i++) begin
                        a = addr + 8'(i);
                        exp_wr_q.push_back({32'(cyc + 1 + i), a, pay_q[i]});
                    end
                    exp_ok_q.push_back(32'(cyc + 1 + int'(len)));
                end
                send(cs ^ csum_delta);
                if (overrun && csum_delta == 0 && cmd == 8'h01 && len > 1) begin
                    idle(1);
                    push_err(cyc + 1, 3'd5);
                    send(8'hA5);
                end
                idle(int'(len) + 3);
            end
        end
        chk("busy_idle", 32'(busy), 32'd0);
        chk("err_code_hold", 32'(err_code), 32'(exp_last_code));
    endtask

    task automatic rand_payload(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] cmd;
        int kind;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_pc_start", 32'(pc_start), 32'd0);
        chk("rst_frame_ok", 32'(frame_ok), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        idle(2);

        // Reference WRITE, then the same frame with CSUM 13.
        pay_q = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h01, 8'h10, 8'h03, 8'h00, 0, 1'b0);
        run_frame(8'h01, 8'h10, 8'h03, 8'h01, 0, 1'b0);

        // START good, START with LEN=1.
        run_frame(8'h02, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        pay_q = '{8'h00};
        run_frame(8'h02, 8'h00, 8'h01, 8'h00, 0, 1'b0);

        // Address wrap 0xFF -> 0x00.
        pay_q = '{8'hAA, 8'hBB};
        run_frame(8'h01, 8'hFF, 8'h02, 8'h00, 0, 1'b0);

        // Leading noise is ignored silently.
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        pay_q = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h01, 8'h10, 8'h03, 8'h00, 0, 1'b0);

        // Unknown command.
        run_frame(8'h07, 8'h00, 8'h00, 8'h00, 0, 1'b0);

        // Length boundaries.
        rand_payload(MAX_LEN);
        run_frame(8'h01, 8'h20, 8'(MAX_LEN), 8'h00, 0, 1'b0);
        run_frame(8'h01, 8'h20, 8'(MAX_LEN + 1), 8'h00, 0, 1'b0);
        run_frame(8'h01, 8'h20, 8'h00, 8'h00, 0, 1'b0);
        pay_q = '{8'h5C};
        run_frame(8'h01, 8'h30, 8'h01, 8'h00, 0, 1'b0);

        // Byte arriving during FLUSH is dropped, flush still completes.
        rand_payload(4);
        run_frame(8'h01, 8'h80, 8'h04, 8'h00, 0, 1'b1);

        // Reset mid-flush: only the writes before reset may appear.
        rand_payload(4);
        send(8'hA5);
        send(8'h01);
        send(8'h40);
        send(8'h04);
        for (int i = 0; i < 4; i++) send(pay_q[i]);
        exp_wr_q.push_back({32'(cyc + 1), 8'h40, pay_q[0]});
        exp_wr_q.push_back({32'(cyc + 2), 8'h41, pay_q[1]});
        send(8'h01 ^ 8'h40 ^ 8'h04 ^ pay_q[0] ^ pay_q[1] ^ pay_q[2] ^ pay_q[3]);
        idle(1);
        rst = 1'b1;
        #1;
        chk("midflush_rst_wr_en", 32'(wr_en), 32'd0);
        chk("midflush_rst_busy", 32'(busy), 32'd0);
        chk("midflush_rst_state", 32'(state_dbg), 32'd0);
        chk("midflush_rst_err_code", 32'(err_code), 32'd0);
        exp_last_code = 3'd0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        idle(8);
        chk("midflush_no_writes", 32'(exp_wr_q.size()), 32'd0);

`ifdef CMD_FRAME_TIMEOUT_EN
        // Silence after A5 01: TIMEOUT exactly, counted from the 01 byte.
        send(8'hA5);
        push_err(cyc + TIMEOUT, 3'd3);
        send(8'h01);
        idle(TIMEOUT + 5);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_code", 32'(err_code), 32'd3);
`endif

        // Random mix of good and corrupted frames with noise and byte gaps.
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                send(b);
            end
            kind = int'($urandom_range(0, 9));
            rand_payload(MAX_LEN);
            case (kind)
                0, 1, 2, 3, 4: run_frame(8'h01, 8'($urandom_range(0, 255)),
                                         8'($urandom_range(1, MAX_LEN)), 8'h00, 2, 1'b0);
                5: run_frame(8'h02, 8'($urandom_range(0, 255)), 8'h00, 8'h00, 2, 1'b0);
                6: begin
                    cmd = 8'($urandom_range(0, 255));
                    if (cmd == 8'h01 || cmd == 8'h02) cmd = 8'h07;
                    run_frame(cmd, 8'h00, 8'h00, 8'h00, 2, 1'b0);
                end
                7: run_frame(8'h01, 8'($urandom_range(0, 255)),
                             8'($urandom_range(MAX_LEN + 1, 255)), 8'h00, 2, 1'b0);
                8: run_frame(8'($urandom_range(1, 2)), 8'($urandom_range(0, 255)),
                             8'h00, 8'($urandom_range(1, 255)), 2, 1'b0);
                default: run_frame(8'h02, 8'h00, 8'($urandom_range(1, 255)), 8'h00, 2, 1'b0);
            endcase
        end

        idle(4);
        chk("end_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        chk("end_err_q_empty", 32'(exp_err_q.size()), 32'd0);
        chk("end_ok_q_empty", 32'(exp_ok_q.size()), 32'd0);
        chk("end_start_q_empty", 32'(exp_start_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
